// File: rtl/a0_uart_monitor_if.sv
// rtl/a0_uart_monitor_if.sv - a0 observation inputs and UART/status outputs of the a0 monitor
interface a0_uart_monitor_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [31:0]                 a0_in;
    logic                        en;
    logic                        tx;
    logic                        busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        overflow;

    modport master (
        output a0_in, en,
        input  tx, busy, fifo_count, overflow
    );

    modport slave (
        input  a0_in, en,
        output tx, busy, fifo_count, overflow
    );
endinterface

// File: rtl/a0_uart_monitor.sv
// rtl/a0_uart_monitor.sv - queues every change of a0 and sends each word LSB byte first over 8N1 UART
// Optional A0_UART_SYNC_EN: prefix each word with a 0xA5 sync byte.
module a0_uart_monitor #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input logic              clk,
    input logic              rst,
    a0_uart_monitor_if.slave mon
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
`ifdef A0_UART_SYNC_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   last_a0_q, last_a0_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    state_t        state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    logic          timer_done;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic [7:0]    cur_byte;

    assign timer_done = (timer_q == TW'(CLKS_PER_BIT - 1));
    assign push_req   = mon.en && (mon.a0_in != last_a0_q);

    always_comb begin
        cur_byte = 8'h00;
`ifdef A0_UART_SYNC_EN
        case (byte_idx_q)
            3'd0:    cur_byte = 8'hA5;
            3'd1:    cur_byte = word_q[7:0];
            3'd2:    cur_byte = word_q[15:8];
            3'd3:    cur_byte = word_q[23:16];
            default: cur_byte = word_q[31:24];
        endcase
`else
        case (byte_idx_q)
            3'd0:    cur_byte = word_q[7:0];
            3'd1:    cur_byte = word_q[15:8];
            3'd2:    cur_byte = word_q[23:16];
            default: cur_byte = word_q[31:24];
        endcase
`endif
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        timer_d    = timer_done ? '0 : timer_q + 1'b1;
        tx_d       = tx_q;
        busy_d     = busy_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                if (count_q != '0) begin
                    pop        = 1'b1;
                    word_d     = mem_q[rd_ptr_q];
                    byte_idx_d = 3'd0;
                    state_d    = START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (timer_done) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = cur_byte[0];
                end
            end
            DATA: begin
                if (timer_done) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = cur_byte[bit_idx_d];
                    end
                end
            end
            default: begin
                if (timer_done) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = START;
                        tx_d       = 1'b0;
                    end else if (count_q != '0) begin
                        // Next word follows straight after the stop bit.
                        pop        = 1'b1;
                        word_d     = mem_q[rd_ptr_q];
                        byte_idx_d = 3'd0;
                        state_d    = START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_comb begin
        last_a0_d  = mon.a0_in;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        // A full queue still accepts a word if the FSM frees a slot this cycle.
        push_ok    = push_req && ((count_q < CW'(FIFO_DEPTH)) || pop);
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= mon.a0_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_a0_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            word_q     <= '0;
            byte_idx_q <= 3'd0;
            bit_idx_q  <= 3'd0;
            timer_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            last_a0_q  <= last_a0_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            timer_q    <= timer_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign mon.tx         = tx_q;
    assign mon.busy       = busy_q;
    assign mon.fifo_count = count_q;
    assign mon.overflow   = overflow_q;
endmodule

// File: tb/tb_a0_uart_monitor.sv
// tb/tb_a0_uart_monitor.sv - directed self-checking bench for a0_uart_monitor
module tb_a0_uart_monitor;
    localparam int N  = 4;
    localparam int FD = 4;
`ifdef A0_UART_SYNC_EN
    localparam int BPW = 5;
`else
    localparam int BPW = 4;
`endif
    localparam int FRAME = BPW * 10 * N;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    a0_uart_monitor_if #(.FIFO_DEPTH(FD)) mif ();

    a0_uart_monitor #(
        .CLKS_PER_BIT(N),
        .FIFO_DEPTH  (FD)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .mon(mif)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    int         rst_epoch = 0;
    int         busy_cycles = 0;
    int         busy_rises = 0;
    int         tx_low = 0;
    logic       busy_prev = 1'b0;
    logic [7:0] rx_byte;
    int         rx_ep;

    always @(negedge rst) rst_epoch++;

    always @(negedge clk) begin
        if (mif.busy === 1'b1) busy_cycles++;
        if (mif.busy === 1'b1 && busy_prev !== 1'b1) busy_rises++;
        if (mif.tx === 1'b0) tx_low++;
        busy_prev = mif.busy;
    end

    // Line receiver: samples mid-bit; frames cut by a reset are discarded.
    always begin : rx_decoder
        @(negedge clk);
        if (rst === 1'b1 && mif.tx === 1'b0) begin
            rx_ep = rst_epoch;
            repeat (N / 2) @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                repeat (N) @(negedge clk);
                rx_byte[j] = mif.tx;
            end
            repeat (N) @(negedge clk);
            if (rx_ep == rst_epoch) begin
                checks++;
                if (mif.tx !== 1'b1) begin
                    errors++;
                    $display("FAIL rx_stop_bit: tx=%b required 1", mif.tx);
                end
                rx_q.push_back(rx_byte);
            end
        end
    end

    task automatic add_word(input logic [31:0] w);
`ifdef A0_UART_SYNC_EN
        exp_q.push_back(8'hA5);
`endif
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (mif.busy === 1'b0 && mif.fifo_count === '0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mif.a0_in = 32'h0;
        mif.en = 1'b1;
        repeat (3) @(negedge clk);
        rx_q.delete();
        exp_q.delete();
        rst = 1'b1;
        busy_cycles = 0;
        busy_rises = 0;
        tx_low = 0;
    endtask

    task automatic test_reset();
        bit ok;
        int bad;
        rst = 1'b1;
        mif.a0_in = 32'hFFFF_FFFF;
        mif.en = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mif.tx !== 1'b1 || mif.busy !== 1'b0 || mif.fifo_count !== '0 || mif.overflow !== 1'b0) begin
                errors++;
                $display("FAIL reset_values: tx=%b busy=%b count=%0d ovf=%b required 1 0 0 0",
                         mif.tx, mif.busy, mif.fifo_count, mif.overflow);
            end
        end
        rst = 1'b1;
        busy_cycles = 0;
        busy_rises = 0;
        @(negedge clk);
        checks++;
        if (mif.fifo_count !== 3'd1 || mif.busy !== 1'b0 || mif.tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_push: count=%0d busy=%b tx=%b required 1 0 1",
                     mif.fifo_count, mif.busy, mif.tx);
        end
        @(negedge clk);
        checks++;
        if (mif.fifo_count !== 3'd0 || mif.busy !== 1'b1 || mif.tx !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_pop: count=%0d busy=%b tx=%b required 0 1 0",
                     mif.fifo_count, mif.busy, mif.tx);
        end
        wait_idle(1000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_idle_timeout: busy=%b required 0", mif.busy);
        end
        add_word(32'hFFFF_FFFF);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        checks++;
        if (rx_q.size() != exp_q.size() || bad != 0) begin
            errors++;
            $display("FAIL reset_bytes: got %0d bytes (%0d wrong) required %0d", rx_q.size(), bad, exp_q.size());
        end
    endtask

    task automatic test_single_word();
        bit ok;
        int bad;
        do_reset();
        mif.a0_in = 32'h1234_5678;
        wait_idle(1000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_idle_timeout: busy=%b required 0", mif.busy);
        end
        checks++;
        if (busy_cycles != FRAME || busy_rises != 1) begin
            errors++;
            $display("FAIL single_busy_len: cycles=%0d rises=%0d required %0d 1", busy_cycles, busy_rises, FRAME);
        end
        checks++;
        if (mif.tx !== 1'b1 || mif.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end_state: tx=%b busy=%b required 1 0", mif.tx, mif.busy);
        end
        add_word(32'h1234_5678);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        checks++;
        if (rx_q.size() != exp_q.size() || bad != 0) begin
            errors++;
            $display("FAIL single_bytes: got %0d bytes (%0d wrong) first=%h required %0d first=%h",
                     rx_q.size(), bad, (rx_q.size() > 0) ? rx_q[0] : 8'hxx, exp_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_stable();
        int bad;
        do_reset();
        mif.a0_in = 32'h0000_0005;
        repeat (1000) @(negedge clk);
        checks++;
        if (busy_rises != 1 || busy_cycles != FRAME || mif.busy !== 1'b0) begin
            errors++;
            $display("FAIL stable_once: rises=%0d cycles=%0d busy=%b required 1 %0d 0",
                     busy_rises, busy_cycles, mif.busy, FRAME);
        end
        add_word(32'h0000_0005);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        checks++;
        if (rx_q.size() != exp_q.size() || bad != 0) begin
            errors++;
            $display("FAIL stable_bytes: got %0d bytes (%0d wrong) required %0d", rx_q.size(), bad, exp_q.size());
        end
    endtask

    task automatic test_back_to_back_overflow();
        bit ok;
        int bad;
        logic [31:0] v;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            v = 32'hA0B0_C000 + 32'(i);
            mif.a0_in = v;
            if (i <= 5) add_word(v);
            @(negedge clk);
        end
        checks++;
        if (mif.fifo_count !== 3'd4 || mif.overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_full: count=%0d ovf=%b required 4 1", mif.fifo_count, mif.overflow);
        end
        wait_idle(3000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL overflow_idle_timeout: busy=%b count=%0d required 0 0", mif.busy, mif.fifo_count);
        end
        checks++;
        if (mif.overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: ovf=%b required 1", mif.overflow);
        end
        checks++;
        if (busy_cycles != 5 * FRAME || busy_rises != 1) begin
            errors++;
            $display("FAIL back_to_back_busy: cycles=%0d rises=%0d required %0d 1", busy_cycles, busy_rises, 5 * FRAME);
        end
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        checks++;
        if (rx_q.size() != exp_q.size() || bad != 0) begin
            errors++;
            $display("FAIL overflow_bytes: got %0d bytes (%0d wrong) required %0d", rx_q.size(), bad, exp_q.size());
        end
    endtask

    task automatic test_en_gating();
        bit ok;
        int bad;
        do_reset();
        mif.en = 1'b0;
        mif.a0_in = 32'h1;
        @(negedge clk);
        mif.a0_in = 32'h2;
        @(negedge clk);
        mif.en = 1'b1;
        @(negedge clk);
        checks++;
        if (mif.busy !== 1'b0 || mif.fifo_count !== '0) begin
            errors++;
            $display("FAIL en_gated_quiet: busy=%b count=%0d required 0 0", mif.busy, mif.fifo_count);
        end
        mif.a0_in = 32'h3;
        wait_idle(1000, ok);
        checks++;
        if (!ok || busy_rises != 1) begin
            errors++;
            $display("FAIL en_one_word: ok=%b rises=%0d required 1 1", ok, busy_rises);
        end
        add_word(32'h3);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        checks++;
        if (rx_q.size() != exp_q.size() || bad != 0) begin
            errors++;
            $display("FAIL en_bytes: got %0d bytes (%0d wrong) required %0d", rx_q.size(), bad, exp_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit hit;
        int bad;
        do_reset();
        mif.a0_in = 32'h1111_1111;
        @(negedge clk);
        mif.a0_in = 32'h2222_2222;
        @(negedge clk);
        mif.a0_in = 32'h3333_3333;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy_cycles >= 11 * N + 2) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit || mif.fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL midframe_setup: reached=%b count=%0d required 1 2", hit, mif.fifo_count);
        end
        rst = 1'b0;
        mif.a0_in = 32'h0;
        #1;
        checks++;
        if (mif.tx !== 1'b1 || mif.busy !== 1'b0 || mif.fifo_count !== '0) begin
            errors++;
            $display("FAIL midframe_async_reset: tx=%b busy=%b count=%0d required 1 0 0",
                     mif.tx, mif.busy, mif.fifo_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        busy_cycles = 0;
        tx_low = 0;
        repeat (500) @(negedge clk);
        checks++;
        if (busy_cycles != 0 || tx_low != 0 || mif.fifo_count !== '0) begin
            errors++;
            $display("FAIL midframe_silent: busy_cycles=%0d tx_low=%0d count=%0d required 0 0 0",
                     busy_cycles, tx_low, mif.fifo_count);
        end
        rx_q.delete();
        mif.a0_in = 32'h0000_00AA;
        wait_idle(1000, ok);
        add_word(32'h0000_00AA);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        checks++;
        if (!ok || rx_q.size() != exp_q.size() || bad != 0) begin
            errors++;
            $display("FAIL midframe_recover: ok=%b got %0d bytes (%0d wrong) required %0d",
                     ok, rx_q.size(), bad, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stable();
        test_back_to_back_overflow();
        test_en_gating();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
